// File: rtl/vector_ram_pkg.sv
// rtl/vector_ram_pkg.sv - shared FSM state codes and address split helpers for banked_vector_ram
package vector_ram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SERVE = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_RESP  = 2'd3;

    // Low address bits select the bank so consecutive words land in different banks.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned num_banks);
        return addr % num_banks;
    endfunction

    // Remaining upper bits select the row inside the bank.
    function automatic int unsigned row_of(input int unsigned addr, input int unsigned num_banks);
        return addr / num_banks;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single-port write-first RAM bank with one-cycle registered read
module ram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_BITS-1:0]   row,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ROW_BITS;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Memory contents are intentionally not reset; a write also returns the new word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[row] <= wdata;
                rdata_q  <= wdata;
            end else begin
                rdata_q  <= mem[row];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_vector_ram.sv
// rtl/banked_vector_ram.sv - multi-lane vector RAM serialising bank conflicts over interleaved banks
module banked_vector_ram
    import vector_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int NUM_BANKS   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]  addr,
    input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]  wdata,
    input  logic                                    write,
    input  logic                                    valid,
    output logic                                    ready,
    output logic [DATA_WIDTH-1:0]                   bdata,
    output logic                                    bvalid,
    input  logic                                    bready,
    output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]  rdata,
    output logic                                    rvalid,
    input  logic                                    rready
);

    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROW_BITS = ADDR_WIDTH - BANK_W;
    localparam int ROW_W    = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int K_W      = $clog2(PARALLELISM + 1);

    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 || NUM_BANKS > (1 << ADDR_WIDTH)) begin : g_bad_banks
        $error("banked_vector_ram: NUM_BANKS must be a power of two in 2..2**ADDR_WIDTH");
    end

    state_t                                 state_q, state_d;
    logic                                   write_q, write_d;
    logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [PARALLELISM-1:0]                 pend_q, pend_d;
    logic [PARALLELISM-1:0]                 gnt_q, gnt_d;
    logic [K_W-1:0]                         k_q, k_d;
    logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [PARALLELISM-1:0][BANK_W-1:0]     lane_bank;
    logic [PARALLELISM-1:0][ROW_W-1:0]      lane_row;
    logic [PARALLELISM-1:0]                 lane_gnt;
    logic [NUM_BANKS-1:0]                   bank_en;
    logic [NUM_BANKS-1:0][ROW_W-1:0]        bank_row;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]   bank_wd;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]   bank_rd;

    // Split every latched lane address into its bank and row.
    always_comb begin
        for (int l = 0; l < PARALLELISM; l++) begin
            lane_bank[l] = BANK_W'(bank_of(32'(addr_q[l]), NUM_BANKS));
            lane_row[l]  = ROW_W'(row_of(32'(addr_q[l]), NUM_BANKS));
        end
    end

    // Per bank, grant the lowest-index pending lane mapped to it while serving.
    always_comb begin
        lane_gnt = '0;
        bank_en  = '0;
        bank_row = '0;
        bank_wd  = '0;
        if (state_q == S_SERVE) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int l = 0; l < PARALLELISM; l++) begin
                    if (!bank_en[b] && pend_q[l] && lane_bank[l] == BANK_W'(b)) begin
                        bank_en[b]  = 1'b1;
                        lane_gnt[l] = 1'b1;
                        bank_row[b] = lane_row[l];
                        bank_wd[b]  = wdata_q[l];
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROW_BITS   (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[b] & ~rst),
            .we    (bank_en[b] & write_q & ~rst),
            .row   (bank_row[b]),
            .wdata (bank_wd[b]),
            .rdata (bank_rd[b])
        );
    end

    // Request FSM, pending mask, grant counter and read-data capture.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        gnt_d   = '0;
        k_d     = k_q;
        rdata_d = rdata_q;

        // A bank's output is valid the cycle after its grant; the lane still points at it.
        for (int l = 0; l < PARALLELISM; l++) begin
            if (gnt_q[l]) begin
                rdata_d[l] = bank_rd[lane_bank[l]];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    write_d = write;
                    pend_d  = '1;
                    k_d     = '0;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                pend_d = pend_q & ~lane_gnt;
                k_d    = k_q + 1'b1;
                gnt_d  = write_q ? '0 : lane_gnt;
                if (pend_d == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_RESP;
            end
            default: begin
                if (write_q ? bready : rready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Register update; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
            gnt_q   <= '0;
            k_q     <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            gnt_q   <= gnt_d;
            k_q     <= k_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready  = ~rst && (state_q == S_IDLE);
    assign rvalid = ~rst && (state_q == S_RESP) && ~write_q;
    assign bvalid = ~rst && (state_q == S_RESP) && write_q;
    assign rdata  = rst ? '0 : rdata_q;
    assign bdata  = rst ? '0 : DATA_WIDTH'(k_q);

endmodule

// File: doc/banked_vector_ram.md
BANKED_VECTOR_RAM -- requirements
Module: banked_vector_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: word-address width per lane.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-003 SHALL have parameter PARALLELISM, default 4: lanes per request.
REQ-004 SHALL have parameter NUM_BANKS, default 4: power of two, 2..2^ADDR_WIDTH; elaboration error otherwise.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock, sole clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 addr  input  [PARALLELISM][ADDR_WIDTH]  per-lane word address.
REQ-009 wdata  input  [PARALLELISM][DATA_WIDTH]  per-lane write data.
REQ-010 write  input  1  1 = write request, 0 = read request.
REQ-011 valid  input  1  request valid.
REQ-012 ready  output  1  request accepted when valid && ready.
REQ-013 bdata  output  DATA_WIDTH  write response: bank-serialisation cycle count K, zero-extended.
REQ-014 bvalid  output  1  write response valid.
REQ-015 bready  input  1  master accepts write response.
REQ-016 rdata  output  [PARALLELISM][DATA_WIDTH]  per-lane read data.
REQ-017 rvalid  output  1  read response valid.
REQ-018 rready  input  1  master accepts read response.

Function
REQ-019 SHALL split each address: bank = addr[B-1:0], row = addr >> B, B = log2(NUM_BANKS); each bank holds 2^(ADDR_WIDTH-B) words.
REQ-020 SHALL assert ready only in IDLE; on accept, SHALL latch addr/wdata/write, set all lanes pending, enter SERVE.
REQ-021 SHALL, each SERVE cycle, grant per bank the lowest-index pending lane mapped to it, access that bank, clear that lane's pending bit.
REQ-022 SHALL count grant cycles K (1..PARALLELISM); conflict-free request gives K=1.
REQ-023 SHALL go SERVE -> DRAIN once pending mask becomes empty; DRAIN lasts exactly one cycle; DRAIN -> RESP.
REQ-024 SHALL capture each granted read lane's bank output one cycle after its grant into the lane's rdata register.
REQ-025 SHALL assert rvalid (read) or bvalid (write), never both, exactly K+1 cycles after the accept edge.
REQ-026 SHALL hold rdata/bdata and rvalid/bvalid stable in RESP until rready/bready; on handshake return to IDLE, ready high next cycle.
REQ-027 SHALL, for a write with duplicate addresses, leave the highest-index lane's data in memory (later grant wins).
REQ-028 SHALL return, for a read with duplicate addresses, the same word on all those lanes.
REQ-029 SHALL ignore valid, rready, bready outside the states that sample them; rready ignored during write responses and vice versa.
REQ-030 SHALL make a read following a write to the same address return the new data.

Reset
REQ-031 SHALL, on rst, force IDLE, clear pending mask and K, drive ready=0, rvalid=0, bvalid=0, rdata=0, bdata=0 during reset; ready=1 first cycle after rst deasserts.
REQ-032 SHALL abort any in-flight request on rst mid-SERVE/DRAIN/RESP with no response; writes already granted may persist.
REQ-033 SHALL NOT reset memory contents.

Structure
REQ-034 SHALL place the state enum (IDLE, SERVE, DRAIN, RESP) and bank/row split helper functions in shared package vector_ram_pkg.
REQ-035 SHALL instantiate NUM_BANKS copies of sub-module ram_bank: single-port, synchronous read (1-cycle), write-first, DATA_WIDTH x 2^(ADDR_WIDTH-B).
REQ-036 Arbitration, pending mask, K counter and response registers SHALL live in banked_vector_ram.

Verification (defaults P=4, NB=4)
REQ-037 Write addr {0,1,2,3}, wdata {A,B,C,D} -> bvalid 2 cycles after accept, bdata=1; read same -> rvalid after 2 cycles, rdata {A,B,C,D}.
REQ-038 Read addr {0,4,8,12} (all bank 0) after prefill -> 4 grant cycles, rvalid 5 cycles after accept, correct per-lane data.
REQ-039 Write addr {5,5,5,5}, wdata {1,2,3,4} -> bdata=4; read {5,0,5,0} -> rdata lanes 0,2 = 4.
REQ-040 Hold rready=0 10 cycles in RESP -> rvalid, rdata, ready=0 stable; rready pulse -> ready=1 next cycle.
REQ-041 Assert rst in SERVE of a 4-conflict read -> rvalid never asserted, ready=1 one cycle after rst release, next request served normally.
REQ-042 Random back-to-back reads/writes against reference model, 10k transactions -> zero mismatches, response latency = K+1.
